shock_pulse_stretcher: RTL and testbench

Multi-channel, parametrised pulse stretcher for shock/impact sensor events. Each channel turns a trigger on its `i_shock` bit into an `o_active` window whose length is set at run time. Retrigger (extend) and holdoff (cooldown) behaviour is selectable per block. It sits between the debounced sensor inputs and the game/effects logic, and generalises the fixed 0.5 s single-channel shock window to N channels with programmable timing.

---
 rtl/shock_pulse_stretcher_pkg.sv | 12 +
 rtl/shock_pulse_stretcher_if.sv | 29 ++
 rtl/shock_pulse_stretcher_channel.sv | 93 +++++++++
 rtl/shock_pulse_stretcher.sv | 41 ++++
 tb/tb_shock_pulse_stretcher.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/shock_pulse_stretcher_pkg.sv
// Shared types and defaults for the multi-channel shock pulse stretcher.
package shock_pkg;

    localparam int SHOCK_CNT_W = 25;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_ACTIVE   = 2'd1,
        S_COOLDOWN = 2'd2
    } shock_state_e;

endpackage

// File: rtl/shock_pulse_stretcher_if.sv
// Bundle of trigger inputs, timing controls and window outputs for the stretcher.
// No handshake: inputs are sampled every i_clk edge, outputs are valid every cycle.
interface shock_pulse_stretcher_if
    import shock_pkg::*;
#(
    parameter int N_CH  = 4,
    parameter int CNT_W = SHOCK_CNT_W
);

    logic [N_CH-1:0]          i_shock;
    logic [CNT_W-1:0]         i_duration;
    logic [CNT_W-1:0]         i_holdoff;
    logic                     i_retrig_en;
    logic [N_CH-1:0]          o_active;
    logic [N_CH-1:0]          o_start;
    logic                     o_any;
    shock_state_e [N_CH-1:0]  dbg_state;

    modport master (
        output i_shock, i_duration, i_holdoff, i_retrig_en,
        input  o_active, o_start, o_any, dbg_state
    );

    modport slave (
        input  i_shock, i_duration, i_holdoff, i_retrig_en,
        output o_active, o_start, o_any, dbg_state
    );

endinterface

// File: rtl/shock_pulse_stretcher_channel.sv
// One stretcher channel: trigger detect, IDLE/ACTIVE/COOLDOWN FSM and its down-counter.
module shock_stretch_channel
    import shock_pkg::*;
#(
    parameter int CNT_W = SHOCK_CNT_W,
    parameter bit EDGE  = 1'b1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_shock,
    input  logic [CNT_W-1:0] i_duration,
    input  logic [CNT_W-1:0] i_holdoff,
    input  logic             i_retrig_en,
    output logic             o_active,
    output logic             o_start,
    output shock_state_e     o_state
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    shock_state_e     state_q, state_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic             shock_q;
    logic             start_q, start_d;
    logic             trig;
    logic [CNT_W-1:0] dur_ld;

    // shock_q resets low, so an input held high through reset fires once in edge mode.
    assign trig   = EDGE ? (i_shock & ~shock_q) : i_shock;
    assign dur_ld = (i_duration == '0) ? ONE : i_duration;

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        start_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (trig) begin
                    state_d = S_ACTIVE;
                    rem_d   = dur_ld;
                    start_d = 1'b1;
                end
            end
            S_ACTIVE: begin
                // A reload wins over expiry landing in the same cycle.
                if (trig && i_retrig_en) begin
                    rem_d = dur_ld;
                end else if (rem_q <= ONE) begin
                    if (i_holdoff != '0) begin
                        state_d = S_COOLDOWN;
                        rem_d   = i_holdoff;
                    end else begin
                        state_d = S_IDLE;
                        rem_d   = '0;
                    end
                end else begin
                    rem_d = rem_q - ONE;
                end
            end
            S_COOLDOWN: begin
                if (rem_q <= ONE) begin
                    state_d = S_IDLE;
                    rem_d   = '0;
                end else begin
                    rem_d = rem_q - ONE;
                end
            end
            default: begin
                state_d = S_IDLE;
                rem_d   = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            rem_q   <= '0;
            shock_q <= 1'b0;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            shock_q <= i_shock;
            start_q <= start_d;
        end
    end

    assign o_active = (state_q == S_ACTIVE);
    assign o_start  = start_q;
    assign o_state  = state_q;

endmodule

// File: rtl/shock_pulse_stretcher.sv
// N-channel shock pulse stretcher: independent per-channel windows plus a combined flag.
module shock_pulse_stretcher
    import shock_pkg::*;
#(
    parameter int N_CH  = 4,
    parameter int CNT_W = SHOCK_CNT_W,
    parameter bit EDGE  = 1'b1
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    shock_pulse_stretcher_if.slave bus
);

    logic [N_CH-1:0]         act_w;
    logic [N_CH-1:0]         start_w;
    shock_state_e [N_CH-1:0] state_w;

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        shock_stretch_channel #(
            .CNT_W (CNT_W),
            .EDGE  (EDGE)
        ) u_ch (
            .i_clk       (i_clk),
            .i_rst_n     (i_rst_n),
            .i_shock     (bus.i_shock[k]),
            .i_duration  (bus.i_duration),
            .i_holdoff   (bus.i_holdoff),
            .i_retrig_en (bus.i_retrig_en),
            .o_active    (act_w[k]),
            .o_start     (start_w[k]),
            .o_state     (state_w[k])
        );
    end

    // o_any is derived only from channel flops, so it carries no input-to-output path.
    assign bus.o_active  = act_w;
    assign bus.o_start   = start_w;
    assign bus.o_any     = |act_w;
    assign bus.dbg_state = state_w;

endmodule

// File: tb/tb_shock_pulse_stretcher.sv
// Directed bench: edge-mode instance (a) and level-mode instance (b) with hand-derived windows.
module tb_shock_pulse_stretcher;
    import shock_pkg::*;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    shock_pulse_stretcher_if #(.N_CH(4), .CNT_W(25)) a_if ();
    shock_pulse_stretcher_if #(.N_CH(4), .CNT_W(25)) b_if ();

    shock_pulse_stretcher #(.N_CH(4), .CNT_W(25), .EDGE(1'b1)) u_a (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (a_if)
    );

    shock_pulse_stretcher #(.N_CH(4), .CNT_W(25), .EDGE(1'b0)) u_b (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (b_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_a(input string tag, input logic [3:0] act, input logic [3:0] st);
        chk({tag, ".act"},   32'(a_if.o_active), 32'(act));
        chk({tag, ".start"}, 32'(a_if.o_start),  32'(st));
        chk({tag, ".any"},   32'(a_if.o_any),    32'(|act));
    endtask

    task automatic chk_b(input string tag, input logic [3:0] act, input logic [3:0] st);
        chk({tag, ".act"},   32'(b_if.o_active), 32'(act));
        chk({tag, ".start"}, 32'(b_if.o_start),  32'(st));
        chk({tag, ".any"},   32'(b_if.o_any),    32'(|act));
    endtask

    initial begin
        shock_state_e exp_st;
        int m;
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        a_if.i_shock = '0; a_if.i_duration = '0; a_if.i_holdoff = '0; a_if.i_retrig_en = 1'b0;
        b_if.i_shock = '0; b_if.i_duration = '0; b_if.i_holdoff = '0; b_if.i_retrig_en = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk_a("rst_a", 4'b0000, 4'b0000);
        chk_b("rst_b", 4'b0000, 4'b0000);
        chk("rst_a.st0", 32'(a_if.dbg_state[0]), 32'(S_IDLE));
        chk("rst_b.st0", 32'(b_if.dbg_state[0]), 32'(S_IDLE));
        rst_n = 1'b1;
        @(negedge clk);
        chk_a("post_rst_a", 4'b0000, 4'b0000);

        // One-cycle pulse on ch0, duration 5
        a_if.i_duration = 25'd5;
        a_if.i_shock    = 4'b0001;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            chk_a($sformatf("d5.c%0d", i), (i <= 5) ? 4'b0001 : 4'b0000, (i == 1) ? 4'b0001 : 4'b0000);
            if (i == 1) a_if.i_shock = 4'b0000;
        end

        // Duration 0 clamps to a single cycle
        a_if.i_duration = 25'd0;
        a_if.i_shock    = 4'b0010;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            chk_a($sformatf("d0.c%0d", i), (i == 1) ? 4'b0010 : 4'b0000, (i == 1) ? 4'b0010 : 4'b0000);
            if (i == 1) a_if.i_shock = 4'b0000;
        end

        // Retrigger on ch2 in window cycle 6 extends to 16 cycles
        a_if.i_duration  = 25'd10;
        a_if.i_retrig_en = 1'b1;
        a_if.i_shock     = 4'b0100;
        for (int i = 1; i <= 18; i++) begin
            @(negedge clk);
            chk_a($sformatf("rt1.c%0d", i), (i <= 16) ? 4'b0100 : 4'b0000, (i == 1) ? 4'b0100 : 4'b0000);
            if (i == 1) a_if.i_shock = 4'b0000;
            if (i == 6) a_if.i_shock = 4'b0100;
            if (i == 7) a_if.i_shock = 4'b0000;
        end

        // Same stimulus on ch3 without retrigger; mid-window duration change is ignored
        a_if.i_retrig_en = 1'b0;
        a_if.i_shock     = 4'b1000;
        for (int i = 1; i <= 13; i++) begin
            @(negedge clk);
            chk_a($sformatf("rt0.c%0d", i), (i <= 10) ? 4'b1000 : 4'b0000, (i == 1) ? 4'b1000 : 4'b0000);
            if (i == 1) a_if.i_shock = 4'b0000;
            if (i == 2) a_if.i_duration = 25'd2;
            if (i == 6) a_if.i_shock = 4'b1000;
            if (i == 7) a_if.i_shock = 4'b0000;
        end

        // Retrigger in the last active cycle wins over expiry
        a_if.i_duration  = 25'd3;
        a_if.i_retrig_en = 1'b1;
        a_if.i_shock     = 4'b0001;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            chk_a($sformatf("rtx.c%0d", i), (i <= 6) ? 4'b0001 : 4'b0000, (i == 1) ? 4'b0001 : 4'b0000);
            if (i == 1) a_if.i_shock = 4'b0000;
            if (i == 3) a_if.i_shock = 4'b0001;
            if (i == 4) a_if.i_shock = 4'b0000;
        end
        a_if.i_retrig_en = 1'b0;

        // Level mode, held high: 4 active, 3 cooldown, 1 idle, repeat
        b_if.i_duration = 25'd4;
        b_if.i_holdoff  = 25'd3;
        b_if.i_shock    = 4'b0001;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            m = (i - 1) % 8;
            exp_st = (m < 4) ? S_ACTIVE : ((m < 7) ? S_COOLDOWN : S_IDLE);
            chk_b($sformatf("ho.c%0d", i), (m < 4) ? 4'b0001 : 4'b0000, (m == 0) ? 4'b0001 : 4'b0000);
            chk($sformatf("ho.c%0d.st", i), 32'(b_if.dbg_state[0]), 32'(exp_st));
        end
        b_if.i_shock = 4'b0000;
        repeat (10) @(negedge clk);
        chk_b("ho.settle", 4'b0000, 4'b0000);

        // Level mode, no holdoff: windows separated by one idle cycle
        b_if.i_duration = 25'd2;
        b_if.i_holdoff  = 25'd0;
        b_if.i_shock    = 4'b0010;
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            m = (i - 1) % 3;
            chk_b($sformatf("b2b.c%0d", i), (m < 2) ? 4'b0010 : 4'b0000, (m == 0) ? 4'b0010 : 4'b0000);
        end
        b_if.i_shock = 4'b0000;

        // All channels at once, then asynchronous reset two cycles into the window
        a_if.i_duration = 25'd8;
        a_if.i_holdoff  = 25'd0;
        a_if.i_shock    = 4'b1111;
        @(negedge clk);
        chk_a("all.c1", 4'b1111, 4'b1111);
        @(negedge clk);
        chk_a("all.c2", 4'b1111, 4'b0000);
        rst_n = 1'b0;
        #1;
        chk_a("all.rst", 4'b0000, 4'b0000);
        chk("all.rst.st3", 32'(a_if.dbg_state[3]), 32'(S_IDLE));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 1; i <= 11; i++) begin
            @(negedge clk);
            chk_a($sformatf("rel.c%0d", i), (i <= 8) ? 4'b1111 : 4'b0000, (i == 1) ? 4'b1111 : 4'b0000);
        end
        a_if.i_shock = 4'b0000;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
